mult_arbiter: RTL and testbench
===============================

Name: mult_arbiter

Overview:
- Shares one sequential 32x32 shift-add multiplier among NUM_REQ requesters.
- The multiplier is handled through its valid/idle/done/acknowledge handshake.
- Selects a requester by round-robin, latches its operands, drives the multiplier's start and acknowledge, captures the 64-bit product and returns it to the owning requester with a done/ack handshake.
- Sits between client blocks and the multiplier controller; it is the only master of that multiplier.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- IDX_W, 2, width of requester index; equals clog2(NUM_REQ).
- TIMEOUT_CYCLES, 48, watchdog limit in WAIT. Used only with MULT_ARB_TIMEOUT_EN.

Ports:
- Clock  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- iReq_Valid  in  NUM_REQ  per-requester operation request; held until its grant
- iReq_A  in  32*NUM_REQ  operand A, requester i at [32*i+31:32*i]
- iReq_B  in  32*NUM_REQ  operand B, same packing
- oReq_Grant  out  NUM_REQ  one-hot, one-cycle pulse: operands accepted
- oResp_Done  out  NUM_REQ  one-hot; result valid for owner, held until ack
- iResp_Ack  in  NUM_REQ  requester acknowledges the result
- oResult  out  64  latched product of the current owner
- oOwner  out  IDX_W  index of the current/last owner
- oBusy  out  1  high in every state except IDLE
- oError  out  1  timeout flag qualified by oResp_Done; tied 0 without the macro
- oMult_A  out  32  operand A to the multiplier
- oMult_B  out  32  operand B to the multiplier
- oMult_Valid  out  1  start pulse to the multiplier
- oMult_Ack  out  1  acknowledge pulse to the multiplier
- iMult_Idle  in  1  multiplier ready for data
- iMult_Done  in  1  multiplier product ready
- iMult_Result  in  64  multiplier product

Behaviour:
- Reset (synchronous, active-high, clock Clock; also applied mid-operation):
  - State goes to IDLE; round-robin pointer to 0.
  - All outputs 0: oReq_Grant, oResp_Done, oResult, oOwner, oBusy, oError, oMult_A, oMult_B, oMult_Valid, oMult_Ack.
  - Any in-flight operation is discarded with no response. The multiplier shares Reset.
- IDLE:
  - If |iReq_Valid and iMult_Idle: pick the first valid index at or after the pointer, wrapping NUM_REQ-1 -> 0.
  - Latch its A/B into oMult_A/oMult_B and its index into oOwner; go to ISSUE.
  - If iMult_Idle is low, stay in IDLE and issue no grant.
- ISSUE, 1 cycle:
  - oMult_Valid=1 and oReq_Grant[owner]=1; go to WAIT.
  - Requester deasserting or changing iReq_Valid/operands during or after ISSUE has no effect; operands are already latched.
- WAIT:
  - When iMult_Done=1: capture iMult_Result into oResult, pulse oMult_Ack for 1 cycle, go to RESP.
  - oMult_Valid stays 0.
- RESP:
  - oResp_Done[owner]=1; oResult stable.
  - On iResp_Ack[owner]=1: drop oResp_Done next cycle, set pointer to (owner+1) mod NUM_REQ, go to IDLE.
  - iResp_Ack from non-owners is ignored at all times.
- Fairness:
  - A requester waits at most NUM_REQ-1 other operations.
  - A request arriving in the same cycle the pointer moves is arbitrated against the new pointer.
- Latency:
  - Arbiter overhead is 1 cycle (IDLE->ISSUE) + 1 cycle (ISSUE) + 1 cycle (done->RESP).
  - Total = multiplier latency + 3 cycles to oResp_Done.
  - Minimum re-arbitration gap is 1 cycle after the ack.
- Arithmetic: unsigned; oResult is the full 64-bit product, no truncation.

Optional Feature:
- Macro MULT_ARB_TIMEOUT_EN.
- Enabled:
  - An 8-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES without iMult_Done: oResult=0, oError=1, pulse oMult_Ack, go to RESP.
  - oError clears with oResp_Done.
- Disabled: WAIT is unbounded; oError is constant 0; no counter logic.

Decomposition:
- Package mult_arb_pkg holds:
  - state encodings ST_IDLE=3'd0, ST_ISSUE=3'd1, ST_WAIT=3'd2, ST_RESP=3'd3
  - WORD_W=32, RESULT_W=64
- Sub-module mult_rr_picker: combinational round-robin search over iReq_Valid from the pointer. Outputs a found flag and a winner index.
- The FSM, operand/result registers and watchdog stay in mult_arbiter.

Test Plan:
- Single request: req0 A=7, B=9 -> Grant[0] pulses once; Done[0] with oResult=63, total latency multiplier+3; ack -> IDLE, pointer=1.
- All four requesters valid, operands A=i+1, B=1000 -> grants in order 0,1,2,3; results 1000, 2000, 3000, 4000 each to the correct owner; no double grant.
- Max operands A=B=32'hFFFFFFFF -> oResult=64'hFFFFFFFE00000001.
- Wrong ack: owner 2 in RESP, iResp_Ack[1]=1 -> stays in RESP with Done[2] held; then Ack[2] -> IDLE.
- Reset mid-operation: Reset asserted in WAIT -> next cycle all outputs 0, pointer 0; new req3 after reset is granted first.
- MULT_ARB_TIMEOUT_EN with TIMEOUT_CYCLES=5 and iMult_Done held 0 -> after 5 WAIT cycles, oMult_Ack pulses; Done[owner]=1, oError=1, oResult=0.

Source files
------------

// File: rtl/mult_arb_pkg.sv
// Shared types and widths for the multiplier arbiter.
// Holds state encodings and data widths.
package mult_arb_pkg;

  localparam int WORD_W   = 32;
  localparam int RESULT_W = 64;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RESP  = 3'd3
  } state_t;

endpackage

// File: rtl/mult_rr_picker.sv
// Combinational round-robin search over request lines.
// Returns the first valid index at or after the pointer.
module mult_rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic               o_found,
  output logic [IDX_W-1:0]   o_idx
);

  // Scan from farthest to nearest so the nearest hit wins.
  always_comb begin
    o_found = 1'b0;
    o_idx   = i_ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (i_valid[(int'(i_ptr) + k) % NUM_REQ]) begin
        o_found = 1'b1;
        o_idx   = IDX_W'((int'(i_ptr) + k) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one sequential multiplier.
// Optional WAIT watchdog enabled by MULT_ARB_TIMEOUT_EN.
module mult_arbiter
  import mult_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int IDX_W          = 2,
  parameter int TIMEOUT_CYCLES = 48
) (
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic [NUM_REQ-1:0]        iReq_Valid,
  input  logic [WORD_W*NUM_REQ-1:0] iReq_A,
  input  logic [WORD_W*NUM_REQ-1:0] iReq_B,
  output logic [NUM_REQ-1:0]        oReq_Grant,
  output logic [NUM_REQ-1:0]        oResp_Done,
  input  logic [NUM_REQ-1:0]        iResp_Ack,
  output logic [RESULT_W-1:0]       oResult,
  output logic [IDX_W-1:0]          oOwner,
  output logic                      oBusy,
  output logic                      oError,
  output logic [WORD_W-1:0]         oMult_A,
  output logic [WORD_W-1:0]         oMult_B,
  output logic                      oMult_Valid,
  output logic                      oMult_Ack,
  input  logic                      iMult_Idle,
  input  logic                      iMult_Done,
  input  logic [RESULT_W-1:0]       iMult_Result
);

  state_t               r_state;
  state_t               w_next;
  logic [IDX_W-1:0]     r_ptr;
  logic [IDX_W-1:0]     r_owner;
  logic [WORD_W-1:0]    r_a;
  logic [WORD_W-1:0]    r_b;
  logic [RESULT_W-1:0]  r_res;
  logic [IDX_W-1:0]     w_win;
  logic                 w_found;
  logic                 w_start;
  logic                 w_own_ack;
  logic                 w_fin;
  logic                 w_tmo;
  logic [NUM_REQ-1:0]   w_own_oh;

  mult_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .i_valid (iReq_Valid),
    .i_ptr   (r_ptr),
    .o_found (w_found),
    .o_idx   (w_win)
  );

  assign w_start   = (r_state == ST_IDLE) && w_found && iMult_Idle;
  assign w_own_ack = (r_state == ST_RESP) && iResp_Ack[r_owner];
  assign w_fin     = (r_state == ST_WAIT) && (iMult_Done || w_tmo);
  assign w_own_oh  = NUM_REQ'(1) << r_owner;

`ifdef MULT_ARB_TIMEOUT_EN
  logic [7:0] r_wdog;
  logic       r_err;

  // Counter sits at zero outside WAIT, so it restarts on every entry.
  always_ff @(posedge Clock) begin
    if (Reset)
      r_wdog <= '0;
    else if (r_state != ST_WAIT)
      r_wdog <= '0;
    else
      r_wdog <= r_wdog + 8'd1;
  end

  assign w_tmo = (r_state == ST_WAIT) && !iMult_Done &&
                 (r_wdog == 8'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge Clock) begin
    if (Reset)
      r_err <= 1'b0;
    else if (w_tmo)
      r_err <= 1'b1;
    else if (w_own_ack)
      r_err <= 1'b0;
  end

  assign oError = r_err && (r_state == ST_RESP);
`else
  assign w_tmo  = 1'b0;
  assign oError = 1'b0;
`endif

  always_ff @(posedge Clock) begin
    if (Reset)
      r_state <= ST_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:  if (w_start) w_next = ST_ISSUE;
      ST_ISSUE: w_next = ST_WAIT;
      ST_WAIT:  if (w_fin) w_next = ST_RESP;
      ST_RESP:  if (w_own_ack) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    oReq_Grant  = '0;
    oResp_Done  = '0;
    oMult_Valid = 1'b0;
    oMult_Ack   = 1'b0;
    oBusy       = 1'b1;
    unique case (r_state)
      ST_IDLE:  oBusy = 1'b0;
      ST_ISSUE: begin
        oMult_Valid = 1'b1;
        oReq_Grant  = w_own_oh;
      end
      ST_WAIT:  oMult_Ack = w_fin;
      ST_RESP:  oResp_Done = w_own_oh;
      default:  oBusy = 1'b0;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_ptr   <= '0;
      r_owner <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
    end else begin
      if (w_start) begin
        r_owner <= w_win;
        r_a     <= iReq_A[WORD_W*w_win +: WORD_W];
        r_b     <= iReq_B[WORD_W*w_win +: WORD_W];
      end
      if (w_fin)
        r_res <= w_tmo ? '0 : iMult_Result;
      if (w_own_ack)
        r_ptr <= (r_owner == IDX_W'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;
    end
  end

  assign oResult = r_res;
  assign oOwner  = r_owner;
  assign oMult_A = r_a;
  assign oMult_B = r_b;

endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: behavioural multiplier plus round-robin reference.
// Timeout scenario runs only when MULT_ARB_TIMEOUT_EN is defined.
module tb_mult_arbiter;

`ifdef MULT_ARB_TIMEOUT_EN
  localparam int TMO = 5;
`else
  localparam int TMO = 48;
`endif

  logic         Clock = 1'b0;
  logic         Reset = 1'b1;
  logic [3:0]   iReq_Valid = '0;
  logic [127:0] iReq_A = '0;
  logic [127:0] iReq_B = '0;
  logic [3:0]   oReq_Grant;
  logic [3:0]   oResp_Done;
  logic [3:0]   iResp_Ack = '0;
  logic [63:0]  oResult;
  logic [1:0]   oOwner;
  logic         oBusy;
  logic         oError;
  logic [31:0]  oMult_A;
  logic [31:0]  oMult_B;
  logic         oMult_Valid;
  logic         oMult_Ack;
  logic         iMult_Idle;
  logic         iMult_Done;
  logic [63:0]  iMult_Result;

  mult_arbiter #(
    .NUM_REQ        (4),
    .IDX_W          (2),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .iReq_Valid   (iReq_Valid),
    .iReq_A       (iReq_A),
    .iReq_B       (iReq_B),
    .oReq_Grant   (oReq_Grant),
    .oResp_Done   (oResp_Done),
    .iResp_Ack    (iResp_Ack),
    .oResult      (oResult),
    .oOwner       (oOwner),
    .oBusy        (oBusy),
    .oError       (oError),
    .oMult_A      (oMult_A),
    .oMult_B      (oMult_B),
    .oMult_Valid  (oMult_Valid),
    .oMult_Ack    (oMult_Ack),
    .iMult_Idle   (iMult_Idle),
    .iMult_Done   (iMult_Done),
    .iMult_Result (iMult_Result)
  );

  always #5 Clock = ~Clock;

  int          n_cmp = 0;
  int          n_err = 0;
  int          mptr = 0;
  int          lat_next = 3;
  int          force_wrong = 0;
  bit          stall = 0;
  bit          blk = 0;
  logic [31:0] opA [4];
  logic [31:0] opB [4];
  logic [63:0] last_res;

  // Behavioural multiplier: product ready lat_next edges after the start.
  logic        m_busy;
  int          m_cnt;
  logic [63:0] m_res;

  always @(posedge Clock) begin
    if (Reset) begin
      m_busy <= 1'b0;
      m_cnt  <= 0;
      m_res  <= '0;
    end else if (oMult_Ack) begin
      m_busy <= 1'b0;
    end else if (oMult_Valid && !m_busy) begin
      m_busy <= 1'b1;
      m_cnt  <= lat_next;
      m_res  <= {32'b0, oMult_A} * {32'b0, oMult_B};
    end else if (m_busy && m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
    end
  end

  assign iMult_Idle   = !m_busy && !blk;
  assign iMult_Done   = m_busy && (m_cnt == 0) && !stall;
  assign iMult_Result = m_res;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    assert (got === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_grant"}, oReq_Grant, 0);
    check({tag, "_done"}, oResp_Done, 0);
    check({tag, "_result"}, oResult, 0);
    check({tag, "_owner"}, oOwner, 0);
    check({tag, "_busy"}, oBusy, 0);
    check({tag, "_error"}, oError, 0);
    check({tag, "_ma"}, oMult_A, 0);
    check({tag, "_mb"}, oMult_B, 0);
    check({tag, "_mvalid"}, oMult_Valid, 0);
    check({tag, "_mack"}, oMult_Ack, 0);
  endtask

  // Serve every requester in mask; expectations come from the arrays
  // opA/opB and the reference pointer mptr.
  task automatic run_ops(input logic [3:0] mask);
    logic [3:0] pend;
    logic [3:0] own_oh;
    int served, want, owner, cyc, ackdly, exp;
    bit acking, inflight, first;
    pend = mask; own_oh = '0;
    served = 0; want = $countones(mask);
    owner = 0; cyc = 0; ackdly = 0; exp = 0;
    acking = 0; inflight = 0; first = 0;
    @(negedge Clock);
    for (int i = 0; i < 4; i++) begin
      iReq_A[32*i +: 32] = opA[i];
      iReq_B[32*i +: 32] = opB[i];
    end
    iReq_Valid = mask;
    while (served < want && cyc < 3000) begin
      @(negedge Clock);
      cyc++;
      lat_next = $urandom_range(1, 4);
      if (acking) begin
        iResp_Ack = '0;
        acking = 0;
        served++;
        inflight = 0;
        mptr = (owner + 1) % 4;
        check("done_drop", oResp_Done, 0);
        check("busy_drop", oBusy, 0);
      end else if (oReq_Grant != 0) begin
        exp = -1;
        for (int k = 3; k >= 0; k--)
          if (pend[(mptr + k) % 4]) exp = (mptr + k) % 4;
        if (exp < 0) exp = 0;
        check("double_grant", inflight, 0);
        check("grant", oReq_Grant, 4'(1) << exp);
        check("mult_valid", oMult_Valid, 1);
        owner = exp;
        own_oh = 4'(1) << exp;
        pend[exp] = 1'b0;
        iReq_Valid[exp] = 1'b0;
        iReq_A[32*exp +: 32] = $urandom;
        iReq_B[32*exp +: 32] = $urandom;
        inflight = 1;
        first = 1;
      end else if (oResp_Done != 0) begin
        check("done_onehot", oResp_Done, own_oh);
        check("result", oResult, {32'b0, opA[owner]} * {32'b0, opB[owner]});
        if (first) begin
          check("owner", oOwner, owner);
          check("no_error", oError, 0);
          ackdly = (force_wrong > 0) ? force_wrong : $urandom_range(0, 2);
          first = 0;
          last_res = oResult;
        end
        if (ackdly == 0) begin
          iResp_Ack = own_oh;
          acking = 1;
        end else begin
          iResp_Ack = (own_oh >> 1) | (own_oh << 3);
          ackdly--;
        end
      end else begin
        iResp_Ack = '0;
      end
    end
    check("served", served, want);
    force_wrong = 0;
  endtask

  initial begin
    int n;
    int g;

    repeat (3) @(negedge Clock);
    check_zero("rst");
    Reset = 1'b0;

    // Multiplier not idle: request must wait.
    blk = 1;
    iReq_Valid = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clock);
      check("blk_grant", oReq_Grant, 0);
      check("blk_busy", oBusy, 0);
    end
    iReq_Valid = '0;
    @(negedge Clock);
    blk = 0;

    for (int i = 0; i < 4; i++) begin
      opA[i] = 32'(i + 1);
      opB[i] = 32'd1000;
    end
    run_ops(4'b1111);

    // Single request latency from assertion to done.
    opA[0] = 32'd7;
    opB[0] = 32'd9;
    @(posedge Clock);
    #1;
    lat_next = 3;
    iReq_A[31:0] = 32'd7;
    iReq_B[31:0] = 32'd9;
    iReq_Valid = 4'b0001;
    n = 0;
    g = 0;
    while (oResp_Done == 0 && n < 100) begin
      @(posedge Clock);
      n++;
      #1;
      if (oReq_Grant[0]) begin
        g++;
        iReq_Valid[0] = 1'b0;
      end
    end
    check("single_latency", n, 3 + 3);
    check("single_grants", g, 1);
    check("single_done", oResp_Done, 4'b0001);
    check("single_result", oResult, 64'd63);
    iResp_Ack = 4'b0001;
    @(posedge Clock);
    #1;
    iResp_Ack = '0;
    check("single_ack_done", oResp_Done, 0);
    check("single_ack_busy", oBusy, 0);
    mptr = 1;

    opA[2] = 32'hFFFF_FFFF;
    opB[2] = 32'hFFFF_FFFF;
    run_ops(4'b0100);
    check("max_result", last_res, 64'hFFFF_FFFE_0000_0001);

    // Non-owner acks held for several cycles before the real one.
    opA[2] = 32'd12345;
    opB[2] = 32'd678;
    force_wrong = 3;
    run_ops(4'b0100);

    for (int b = 0; b < 15; b++) begin
      for (int i = 0; i < 4; i++) begin
        case ($urandom_range(0, 3))
          0: opA[i] = 32'h0;
          1: opA[i] = 32'hFFFF_FFFF;
          default: opA[i] = $urandom;
        endcase
        opB[i] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      end
      run_ops(4'($urandom_range(1, 15)));
    end

    // Leave the pointer at 2, then reset during WAIT of an op by 2.
    opA[1] = 32'd11;
    opB[1] = 32'd13;
    run_ops(4'b0010);
    @(negedge Clock);
    lat_next = 20;
    iReq_A[64 +: 32] = 32'hDEAD_BEEF;
    iReq_B[64 +: 32] = 32'd3;
    iReq_Valid = 4'b0100;
    n = 0;
    while (oReq_Grant == 0 && n < 50) begin
      @(negedge Clock);
      n++;
    end
    check("mid_grant", oReq_Grant, 4'b0100);
    iReq_Valid = '0;
    repeat (2) @(negedge Clock);
    check("mid_busy", oBusy, 1);
    Reset = 1'b1;
    @(negedge Clock);
    check_zero("midrst");
    Reset = 1'b0;
    mptr = 0;
    opA[1] = 32'd5;  opB[1] = 32'd6;
    opA[3] = 32'd21; opB[3] = 32'd2;
    run_ops(4'b1010);
    opA[3] = 32'd100; opB[3] = 32'd100;
    run_ops(4'b1000);

`ifdef MULT_ARB_TIMEOUT_EN
    stall = 1;
    @(negedge Clock);
    iReq_Valid = 4'b0010;
    n = 0;
    while (oReq_Grant == 0 && n < 50) begin
      @(negedge Clock);
      n++;
    end
    check("tmo_grant", oReq_Grant, 4'b0010);
    iReq_Valid = '0;
    n = 0;
    do begin
      @(negedge Clock);
      n++;
    end while (!oMult_Ack && n < 50);
    check("tmo_wait", n, 5);
    @(negedge Clock);
    check("tmo_done", oResp_Done, 4'b0010);
    check("tmo_error", oError, 1);
    check("tmo_result", oResult, 0);
    iResp_Ack = 4'b0010;
    @(negedge Clock);
    iResp_Ack = '0;
    check("tmo_err_clr", oError, 0);
    check("tmo_done_clr", oResp_Done, 0);
    stall = 0;
    mptr = 2;
    opA[0] = 32'd4; opB[0] = 32'd4;
    run_ops(4'b0001);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
